// File: rtl/gcd_pkg.sv
// gcd_pkg: operand width, operand-pair struct and FSM state enum shared by the gcd op queue.
package gcd_pkg;
   localparam int W = 4;
   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
endpackage

// File: rtl/gcd_op_queue_if.sv
// gcd_op_queue_if: producer, engine and result-stream signals of gcd_op_queue.
// Ports (queue view): push_i/op_a_i/op_b_i in, full_o/overflow_o out; req_o/a_o/b_o out,
// busy_i/valid_i/result_val_i in; res_valid_o/result_val_o out, res_ready_i in.
interface gcd_op_queue_if;
   import gcd_pkg::*;
   logic         push_i;
   logic [W-1:0] op_a_i;
   logic [W-1:0] op_b_i;
   logic         full_o;
   logic         overflow_o;
   logic         req_o;
   logic [W-1:0] a_o;
   logic [W-1:0] b_o;
   logic         busy_i;
   logic         valid_i;
   logic [W-1:0] result_val_i;
   logic         res_valid_o;
   logic         res_ready_i;
   logic [W-1:0] result_val_o;
   modport master (
      output push_i, op_a_i, op_b_i, busy_i, valid_i, result_val_i, res_ready_i,
      input  full_o, overflow_o, req_o, a_o, b_o, res_valid_o, result_val_o
   );
   modport slave (
      input  push_i, op_a_i, op_b_i, busy_i, valid_i, result_val_i, res_ready_i,
      output full_o, overflow_o, req_o, a_o, b_o, res_valid_o, result_val_o
   );
endinterface

// File: rtl/gcd_pair_fifo.sv
// gcd_pair_fifo: DEPTH-entry circular FIFO of operand pairs.
// Ports: clk_i, rst_ni (async active-low); push_i/pair_i write; pop_i read;
// full_o, empty_o status; head_o oldest entry.
module gcd_pair_fifo import gcd_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  push_i,
   input  pair_t pair_i,
   input  logic  pop_i,
   output logic  full_o,
   output logic  empty_o,
   output pair_t head_o
);
   localparam int AW = $clog2(DEPTH);
   pair_t         mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          wr, rd;
   // full is judged on the current count, so a push into a full FIFO is dropped even if a pop happens
   assign wr      = push_i && !full_o;
   assign rd      = pop_i && !empty_o;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o  = mem_q[rd_q];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr) wr_q <= wr_q + 1'b1;
         if (rd) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
      end
   end
   always_ff @(posedge clk_i) begin
      if (wr) mem_q[wr_q] <= pair_i;
   end
endmodule

// File: rtl/gcd_op_queue.sv
// gcd_op_queue: queues operand pairs and feeds them one at a time to a gcd engine, streaming results in order.
// Ports: clk_i, rst_ni (async active-low); bus (gcd_op_queue_if.slave) carries push, engine and result signals.
// Option: GCD_QUEUE_ZERO_BYPASS_EN answers pairs with a zero operand locally (a|b) without using the engine.
module gcd_op_queue import gcd_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   gcd_op_queue_if.slave bus
);
   state_t       state_q, state_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic         overflow_q, full, empty, leave, pop, zero;
   pair_t        head;
   gcd_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (bus.push_i),
      .pair_i  ({bus.op_a_i, bus.op_b_i}),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );
   // leave: the FSM is free to start a new pair this edge (idle, or result being accepted)
   assign leave = state_q == IDLE || (state_q == OUT && bus.res_ready_i);
   assign pop   = leave && !empty && !bus.busy_i;
`ifdef GCD_QUEUE_ZERO_BYPASS_EN
   assign zero = head.a == '0 || head.b == '0;
`else
   assign zero = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      if (leave) begin
         state_d = pop ? (zero ? OUT : REQ) : IDLE;
         if (pop) begin
            a_d   = head.a;
            b_d   = head.b;
            res_d = zero ? (head.a | head.b) : res_q;
         end
      end else if (state_q == REQ) begin
         state_d = WAIT;
      end else if (state_q == WAIT && bus.valid_i) begin
         state_d = OUT;
         res_d   = bus.result_val_i;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         overflow_q <= overflow_q || (bus.push_i && full);
      end
   end
   assign bus.req_o        = state_q == REQ;
   assign bus.a_o          = a_q;
   assign bus.b_o          = b_q;
   assign bus.res_valid_o  = state_q == OUT;
   assign bus.result_val_o = res_q;
   assign bus.full_o       = full;
   assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_gcd_op_queue.sv
// tb_gcd_op_queue: directed self-checking bench for gcd_op_queue with a small gcd engine model.
module tb_gcd_op_queue;
   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   int         checks = 0;
   int         errs = 0;
   int         req_cnt = 0;
   logic       stall = 1'b0;
   logic       e_busy = 1'b0;
   logic       e_valid = 1'b0;
   logic [3:0] e_res = '0;
   logic [3:0] ea, eb;
   int         e_cnt = 0;
   logic [3:0] rq[$];
   gcd_op_queue_if bus();
   gcd_op_queue #(.DEPTH(4)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave));
   assign bus.busy_i       = e_busy | stall;
   assign bus.valid_i      = e_valid;
   assign bus.result_val_i = e_res;
   always #5 clk = ~clk;
   function automatic logic [3:0] gcd(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] x = a, y = b, t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction
   // engine: busy for 3 cycles after a request, then a one-cycle valid with the result
   always @(negedge clk) begin
      if (!rst_ni) begin
         e_busy = 0; e_valid = 0; e_cnt = 0;
      end else begin
         if (e_valid) e_valid = 0;
         if (e_cnt > 0) begin
            e_cnt--;
            if (e_cnt == 0) begin e_busy = 0; e_valid = 1; e_res = gcd(ea, eb); end
         end else if (bus.req_o) begin
            ea = bus.a_o; eb = bus.b_o; e_busy = 1; e_cnt = 3;
         end
      end
   end
   always @(negedge clk) if (bus.req_o) req_cnt++;
   task automatic do_reset();
      @(negedge clk);
      rst_ni = 0;
      bus.push_i = 0; bus.op_a_i = 0; bus.op_b_i = 0; bus.res_ready_i = 0; stall = 0;
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1;
   endtask
   task automatic push(input logic [3:0] a, input logic [3:0] b);
      bus.push_i = 1; bus.op_a_i = a; bus.op_b_i = b;
      @(negedge clk);
      bus.push_i = 0;
   endtask
   task automatic wait_res();
      logic ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin
         if (bus.res_valid_o) ok = 1;
         else @(negedge clk);
      end
      checks++;
      if (!ok) begin errs++; $display("FAIL wait_res: res_valid_o=0 after 100 cycles, required 1"); end
   endtask
   task automatic collect(input int n);
      rq.delete();
      for (int c = 0; c < 200 && rq.size() < n; c++) begin
         @(negedge clk);
         if (bus.res_valid_o && bus.res_ready_i) rq.push_back(bus.result_val_o);
      end
   endtask
   task automatic accept();
      bus.res_ready_i = 1;
      @(negedge clk);
      bus.res_ready_i = 0;
   endtask
   task automatic test_reset();
      rst_ni = 0;
      #1;
      checks++; if (bus.req_o !== 1'b0) begin errs++; $display("FAIL reset_req: got %b want 0", bus.req_o); end
      checks++; if ({bus.a_o, bus.b_o} !== 8'h00) begin errs++; $display("FAIL reset_ab: got %h want 00", {bus.a_o, bus.b_o}); end
      checks++; if ({bus.res_valid_o, bus.result_val_o} !== 5'h0) begin errs++; $display("FAIL reset_res: got %h want 0", {bus.res_valid_o, bus.result_val_o}); end
      checks++; if ({bus.full_o, bus.overflow_o} !== 2'b00) begin errs++; $display("FAIL reset_flags: got %b want 00", {bus.full_o, bus.overflow_o}); end
      do_reset();
   endtask
   task automatic test_single();
      int r0 = req_cnt;
      push(4'd12, 4'd8);
      checks++; if (bus.req_o !== 1'b0) begin errs++; $display("FAIL lat_n1: req_o=%b want 0", bus.req_o); end
      @(negedge clk);
      checks++; if (bus.req_o !== 1'b1) begin errs++; $display("FAIL lat_n2: req_o=%b want 1", bus.req_o); end
      checks++; if ({bus.a_o, bus.b_o} !== {4'd12, 4'd8}) begin errs++; $display("FAIL single_ops: got %0d,%0d want 12,8", bus.a_o, bus.b_o); end
      wait_res();
      repeat (3) @(negedge clk);
      checks++; if ({bus.res_valid_o, bus.result_val_o} !== {1'b1, 4'd4}) begin errs++; $display("FAIL single_res: valid=%b val=%0d want 1,4", bus.res_valid_o, bus.result_val_o); end
      checks++; if (req_cnt - r0 !== 1) begin errs++; $display("FAIL single_reqs: got %0d want 1", req_cnt - r0); end
      accept();
      checks++; if (bus.res_valid_o !== 1'b0) begin errs++; $display("FAIL single_accept: res_valid_o=%b want 0", bus.res_valid_o); end
   endtask
   task automatic test_back_to_back();
      int r0 = req_cnt;
      logic [3:0] exp [3] = '{4'd3, 4'd5, 4'd1};
      bus.res_ready_i = 1;
      bus.push_i = 1; bus.op_a_i = 9; bus.op_b_i = 6;
      @(negedge clk); bus.op_a_i = 15; bus.op_b_i = 10;
      @(negedge clk); bus.op_a_i = 7; bus.op_b_i = 3;
      @(negedge clk); bus.push_i = 0;
      collect(3);
      checks++; if (rq.size() !== 3) begin errs++; $display("FAIL b2b_count: got %0d want 3", rq.size()); end
      for (int i = 0; i < 3 && i < rq.size(); i++) begin
         checks++; if (rq[i] !== exp[i]) begin errs++; $display("FAIL b2b_res%0d: got %0d want %0d", i, rq[i], exp[i]); end
      end
      checks++; if (req_cnt - r0 !== 3) begin errs++; $display("FAIL b2b_reqs: got %0d want 3", req_cnt - r0); end
      bus.res_ready_i = 0;
   endtask
   task automatic test_overflow();
      logic [3:0] pa [5] = '{4'd2, 4'd3, 4'd5, 4'd8, 4'd6};
      logic [3:0] pb [5] = '{4'd4, 4'd9, 4'd10, 4'd12, 4'd9};
      logic [3:0] exp [4] = '{4'd2, 4'd3, 4'd5, 4'd4};
      int r0;
      do_reset();
      stall = 1;
      r0 = req_cnt;
      for (int i = 0; i < 5; i++) begin
         bus.push_i = 1; bus.op_a_i = pa[i]; bus.op_b_i = pb[i];
         @(negedge clk);
         if (i == 3) begin
            checks++; if ({bus.full_o, bus.overflow_o} !== 2'b10) begin errs++; $display("FAIL ovf_full4: full,ovf=%b want 10", {bus.full_o, bus.overflow_o}); end
         end
      end
      bus.push_i = 0;
      checks++; if ({bus.full_o, bus.overflow_o} !== 2'b11) begin errs++; $display("FAIL ovf_drop: full,ovf=%b want 11", {bus.full_o, bus.overflow_o}); end
      checks++; if (req_cnt - r0 !== 0) begin errs++; $display("FAIL ovf_stall_reqs: got %0d want 0", req_cnt - r0); end
      stall = 0;
      bus.res_ready_i = 1;
      collect(5);
      bus.res_ready_i = 0;
      checks++; if (rq.size() !== 4) begin errs++; $display("FAIL ovf_count: got %0d want 4", rq.size()); end
      for (int i = 0; i < 4 && i < rq.size(); i++) begin
         checks++; if (rq[i] !== exp[i]) begin errs++; $display("FAIL ovf_res%0d: got %0d want %0d", i, rq[i], exp[i]); end
      end
      checks++; if (bus.overflow_o !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o); end
      do_reset();
      checks++; if (bus.overflow_o !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", bus.overflow_o); end
   endtask
   task automatic test_hold();
      int r0 = req_cnt;
      push(4'd12, 4'd8);
      push(4'd9, 4'd6);
      wait_res();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if ({bus.res_valid_o, bus.result_val_o} !== {1'b1, 4'd4}) begin errs++; $display("FAIL hold_stable%0d: valid=%b val=%0d want 1,4", i, bus.res_valid_o, bus.result_val_o); end
      end
      checks++; if (req_cnt - r0 !== 1) begin errs++; $display("FAIL hold_reqs: got %0d want 1", req_cnt - r0); end
      accept();
      wait_res();
      checks++; if (bus.result_val_o !== 4'd3) begin errs++; $display("FAIL hold_second: got %0d want 3", bus.result_val_o); end
      checks++; if (req_cnt - r0 !== 2) begin errs++; $display("FAIL hold_reqs2: got %0d want 2", req_cnt - r0); end
      accept();
   endtask
   task automatic test_reset_mid();
      int r0;
      bus.push_i = 1; bus.op_a_i = 12; bus.op_b_i = 8;
      @(negedge clk); bus.op_a_i = 9; bus.op_b_i = 6;
      @(negedge clk); bus.op_a_i = 15; bus.op_b_i = 10;
      @(negedge clk); bus.push_i = 0;
      rst_ni = 0;
      #1;
      checks++; if ({bus.req_o, bus.a_o, bus.b_o, bus.res_valid_o, bus.result_val_o, bus.full_o, bus.overflow_o} !== 16'h0) begin
         errs++; $display("FAIL mid_reset_outs: got %h want 0000", {bus.req_o, bus.a_o, bus.b_o, bus.res_valid_o, bus.result_val_o, bus.full_o, bus.overflow_o});
      end
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1;
      r0 = req_cnt;
      repeat (8) @(negedge clk);
      checks++; if (req_cnt - r0 !== 0) begin errs++; $display("FAIL mid_no_req: got %0d want 0", req_cnt - r0); end
      checks++; if (bus.res_valid_o !== 1'b0) begin errs++; $display("FAIL mid_no_res: got %b want 0", bus.res_valid_o); end
      push(4'd4, 4'd6);
      wait_res();
      checks++; if (bus.result_val_o !== 4'd2) begin errs++; $display("FAIL mid_fresh: got %0d want 2", bus.result_val_o); end
      checks++; if (req_cnt - r0 !== 1) begin errs++; $display("FAIL mid_fresh_reqs: got %0d want 1", req_cnt - r0); end
      accept();
   endtask
   task automatic test_zero();
      int r0 = req_cnt;
      push(4'd0, 4'd9);
`ifdef GCD_QUEUE_ZERO_BYPASS_EN
      wait_res();
      checks++; if (bus.result_val_o !== 4'd9) begin errs++; $display("FAIL zero_res: got %0d want 9", bus.result_val_o); end
      checks++; if (req_cnt - r0 !== 0) begin errs++; $display("FAIL zero_reqs: got %0d want 0", req_cnt - r0); end
`else
      @(negedge clk);
      checks++; if ({bus.req_o, bus.a_o, bus.b_o} !== {1'b1, 4'd0, 4'd9}) begin errs++; $display("FAIL zero_req: req,a,b=%b,%0d,%0d want 1,0,9", bus.req_o, bus.a_o, bus.b_o); end
      wait_res();
      checks++; if (bus.result_val_o !== 4'd9) begin errs++; $display("FAIL zero_res: got %0d want 9", bus.result_val_o); end
      checks++; if (req_cnt - r0 !== 1) begin errs++; $display("FAIL zero_reqs: got %0d want 1", req_cnt - r0); end
`endif
      accept();
   endtask
   initial begin
      bus.push_i = 0; bus.op_a_i = 0; bus.op_b_i = 0; bus.res_ready_i = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_hold();
      test_reset_mid();
      test_zero();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule

// File: doc/gcd_op_queue.md
GCD_OP_QUEUE -- requirements
Module: gcd_op_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-pair FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port push_i  input  1  write one operand pair this cycle.
REQ-005 SHALL have ports op_a_i / op_b_i  input  4 each  operand pair written on push_i.
REQ-006 SHALL have port full_o  output  1  FIFO holds DEPTH entries.
REQ-007 SHALL have port overflow_o  output  1  sticky flag: push_i seen while full_o.
REQ-008 SHALL have ports req_o  output  1, a_o / b_o  output  4 each  request and operands to the gcd engine.
REQ-009 SHALL have ports busy_i, valid_i  input  1 each, result_val_i  input  4  engine status and result.
REQ-010 SHALL have ports res_valid_o  output  1, res_ready_i  input  1, result_val_o  output  4  result stream.

Function
REQ-011 SHALL store pairs in a DEPTH-entry circular FIFO; pointers wrap from DEPTH-1 to 0; an occupancy count of width log2(DEPTH)+1 distinguishes full from empty.
REQ-012 SHALL ignore push_i while full_o=1 (pair dropped) and set overflow_o the same edge.
REQ-013 SHALL accept push_i in the same cycle as a pop; when full, simultaneous push and pop still drops the push (full is evaluated before the pop).
REQ-014 SHALL implement FSM states IDLE, REQ, WAIT, OUT.
REQ-015 IDLE -> REQ when FIFO non-empty and busy_i=0; head pair is popped into registered a_o/b_o on that edge.
REQ-016 REQ: req_o=1 for exactly one cycle; -> WAIT next edge.
REQ-017 WAIT: req_o=0, a_o/b_o held stable; on valid_i=1 capture result_val_i into result_val_o and -> OUT; busy_i is ignored in WAIT.
REQ-018 OUT: res_valid_o=1, result_val_o stable until res_ready_i=1; on that edge -> IDLE (or directly REQ if FIFO non-empty and busy_i=0).
REQ-019 valid_i outside WAIT SHALL be ignored.
REQ-020 Latency, empty FIFO to req_o: push at edge N -> req_o high in cycle N+2 (IDLE sees non-empty at N+1).
REQ-021 Only one request outstanding at any time; results returned strictly in push order.

Reset
REQ-022 On rst_ni=0, asynchronously: FIFO empty, pointers 0, FSM IDLE, req_o=0, a_o=b_o=0, res_valid_o=0, result_val_o=0, full_o=0, overflow_o=0.
REQ-023 Reset mid-operation SHALL discard all queued pairs and any pending result; no req_o pulse on reset release.

Configuration
REQ-024 Macro GCD_QUEUE_ZERO_BYPASS_EN: when defined, a popped pair with a_o=0 or b_o=0 SHALL skip REQ/WAIT, go IDLE -> OUT with result_val_o = a|b (gcd(0,x)=x, gcd(0,0)=0), no req_o pulse.
REQ-025 Without GCD_QUEUE_ZERO_BYPASS_EN, every pair including zero operands SHALL be sent to the engine.

Structure
REQ-026 Shared package gcd_pkg SHALL hold the operand width constant (4), the operand-pair struct typedef and the FSM state enum.
REQ-027 FIFO SHALL be a separate sub-module gcd_pair_fifo (push/pop/full/empty/head); FSM and result register stay in gcd_op_queue.

Verification
REQ-028 Push (12,8), engine model: busy 3 cycles then valid_i with 4 -> one req_o pulse, a_o=12,b_o=8, res_valid_o=1, result_val_o=4 held until res_ready_i.
REQ-029 Push (9,6),(15,10),(7,3) back-to-back, res_ready_i=1 -> results 3,5,1 in order, exactly three req_o pulses.
REQ-030 DEPTH=4, engine stalled busy_i=1, push 5 pairs -> full_o=1 after 4th, 5th dropped, overflow_o=1 until reset.
REQ-031 Hold res_ready_i=0 with 2 pairs queued -> no second req_o until result accepted; result_val_o stable throughout.
REQ-032 Reset asserted in WAIT with 2 pairs queued -> all outputs 0, no req_o after release, fresh push (4,6) yields result 2.
REQ-033 Push (0,9): with GCD_QUEUE_ZERO_BYPASS_EN -> result 9, no req_o; without -> req_o pulse, a_o=0, b_o=9.
